vram_arbiter: RTL
=================

# vram_arbiter

Single-port VRAM access scheduler between the display readout path and the host bus. Display fetches have absolute priority and get a slot every cycle they request. Host writes are posted into a small FIFO and retired in idle cycles, mostly during horizontal blanking. Host reads are synchronized, ordered behind pending writes, and returned on a held data register.

## Interface
Parameters:
- ADDR_W, 13: VRAM address width.
- DATA_W, 8: VRAM data width.
- WFIFO_DEPTH, 4: posted-write FIFO entries; must be a power of 2, ≥2.

Ports:
- clk  in  1  VGA dot clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- dispReq  in  1  readout requests a VRAM read this cycle.
- dispAddr  in  ADDR_W  readout address.
- dispData  out  DATA_W  display read data.
- dispValid  out  1  dispData valid; set exactly 1 cycle after the matching dispReq.
- nHostWr  in  1  raw asynchronous host write strobe, active-low.
- nHostRd  in  1  raw asynchronous host read strobe, active-low.
- hostAddr  in  ADDR_W  raw host address.
- hostWrData  in  DATA_W  raw host write data.
- hostRdData  out  DATA_W  last host read result; held until the next read completes.
- hostRdValid  out  1  hostRdData is current for the active host read.
- wrFull  out  1  FIFO full.
- wrOverflow  out  1  sticky: a host write was dropped.
- vramAddr  out  ADDR_W  VRAM address; combinational from the current grant.
- vramWrData  out  DATA_W  VRAM write data.
- vramWe  out  1  VRAM write enable.
- vramRdData  in  DATA_W  VRAM read data; 1-cycle registered latency.

## Operation
- nHostWr and nHostRd each pass through a 2-flop synchronizer plus an edge register. A falling edge produces a 1-cycle strobe on cycle E, which is 3 clk after the pin falls.
- Host contract: hostAddr and hostWrData stay stable while the strobe is low, for at least 4 clk.
- Write strobe at E: {hostAddr, hostWrData} is pushed into the FIFO.
  - If the FIFO is full, the write is dropped and wrOverflow is set.
  - Push and pop in the same cycle are legal; the FIFO count is unchanged.
- Read strobe at E: sets rdPending; hostRdValid is cleared.
- Grant priority each cycle:
  1. dispReq=1 → display read.
  2. Else FIFO non-empty → pop head, vramWe=1.
  3. Else rdPending → host read issue.
  4. Else idle: vramAddr=dispAddr, vramWe=0.
- Reads never bypass queued writes. This guarantees read-after-write coherence.
- FSM states:
  - IDLE: default.
  - RD_ISSUE: host read granted this cycle, vramAddr=host address latched at E.
  - RD_CAPTURE: next cycle; hostRdData←vramRdData, hostRdValid←1, rdPending←0, return to IDLE.
- Display grants are independent of FSM state. A display read may occur during RD_CAPTURE.
- hostRdValid clears when the synchronized nHostRd returns high.
- Reset mid-operation clears the FIFO, rdPending, the FSM and the sticky flag. Host operations in flight are lost.

## Timing
Reset values:
- dispData=0, dispValid=0, hostRdData=0, hostRdValid=0.
- wrFull=0, wrOverflow=0, vramWe=0.
- FSM=IDLE, FIFO empty. Synchronizer flops reset to 1 (strobes inactive).

Latencies:
- Display read: dispReq at cycle N → dispValid and data at N+1. No stalls, ever.
- Host write, display idle: strobe at E → vramWe at E+1.
- Host read, display idle and FIFO empty: strobe at E → RD_ISSUE at E+1 → hostRdValid at E+2, i.e. 5 clk after the pin falls.

Boundary rules:
- Continuous dispReq starves host traffic indefinitely; there is no timeout. The readout's blanking guarantees at least 160 free cycles per line.
- wrFull is asserted combinationally from the FIFO count.
- A new read strobe while rdPending=1 re-latches the address. Only one read is outstanding.
- Pointer wrap: FIFO pointers are log2(DEPTH)+1 bits. full = MSBs differ and LSBs equal.

## Configuration
- VRAM_ARB_HOST_READ_EN defined: host read path, FSM read states and hostRdData register are present.
- Undefined: nHostRd is ignored and hostRdData/hostRdValid are tied 0. The FSM reduces to IDLE and grants are display then FIFO only.

## Structure
- Package vram_arb_pkg holds:
  - ADDR_W and DATA_W defaults.
  - FSM state enum {IDLE, RD_ISSUE, RD_CAPTURE}.
  - Grant-type enum {G_DISP, G_WR, G_RD, G_NONE}.
- One sub-module, vram_wr_fifo: synchronous FIFO, width ADDR_W+DATA_W, with push/pop/full/empty.
- Synchronizers and FSM stay in the top module.

## Test plan
- Idle write: dispReq=0, write 0x5A to 0x0123 → vramWe=1, vramAddr=0x0123, vramWrData=0x5A exactly 4 clk after nHostWr falls.
- Display priority: dispReq held 10 cycles during a host write → no vramWe until dispReq drops, then write issued the next cycle; dispValid tracks dispReq +1 throughout.
- RAW ordering: 4 writes then a read of the last address, issued during dispReq=1 → after dispReq drops, 4 writes retire in order, then the read; hostRdData equals the last written byte.
- Overflow: 5 writes with WFIFO_DEPTH=4 and dispReq held high → wrFull=1 after the 4th, wrOverflow=1 after the 5th; only 4 writes reach VRAM.
- Async reset asserted with 2 FIFO entries and rdPending=1 → all outputs take reset values; no vramWe after release.
- Build without VRAM_ARB_HOST_READ_EN: read strobe → hostRdValid stays 0 and vramAddr never equals hostAddr outside write grants.

Source files
------------

// File: rtl/vram_arb_pkg.sv
// Shared types and defaults for the VRAM arbiter.
//   ADDR_W_DEFAULT / DATA_W_DEFAULT : default VRAM address / data widths
//   arbState_t                      : host-read FSM states
//   grant_t                         : per-cycle VRAM slot owner
package vram_arb_pkg;

   localparam int unsigned ADDR_W_DEFAULT = 13;
   localparam int unsigned DATA_W_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE,
      RD_ISSUE,
      RD_CAPTURE
   } arbState_t;

   typedef enum logic [1:0] {
      G_DISP,
      G_WR,
      G_RD,
      G_NONE
   } grant_t;

endpackage

// File: rtl/vram_wr_fifo.sv
// Posted-write FIFO for the VRAM arbiter.
//   clk, rst (async, active-high)
//   push/pushData : enqueue (ignored when full)
//   pop/popData   : dequeue head; popData always shows the current head
//   full/empty    : combinational status from the pointers
// DEPTH must be a power of 2 and at least 2.
module vram_wr_fifo #(
   parameter int unsigned WIDTH = 21,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] pushData,
   input  logic             pop,
   output logic [WIDTH-1:0] popData,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] PTR_ONE = 1;

   logic [WIDTH-1:0] mem [DEPTH];
   // One extra MSB per pointer distinguishes full from empty.
   logic [PTR_W:0]   wrPtrQ, rdPtrQ;
   logic             doPush, doPop;

   assign empty   = (wrPtrQ == rdPtrQ);
   assign full    = (wrPtrQ[PTR_W] != rdPtrQ[PTR_W]) &&
                    (wrPtrQ[PTR_W-1:0] == rdPtrQ[PTR_W-1:0]);
   assign doPush  = push && !full;
   assign doPop   = pop && !empty;
   assign popData = mem[rdPtrQ[PTR_W-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtrQ <= '0;
         rdPtrQ <= '0;
      end else begin
         if (doPush) wrPtrQ <= wrPtrQ + PTR_ONE;
         if (doPop)  rdPtrQ <= rdPtrQ + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (doPush) mem[wrPtrQ[PTR_W-1:0]] <= pushData;
   end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM scheduler: display readout, posted host writes, host reads.
//   clk, rst (async, active-high)
//   dispReq/dispAddr -> dispData/dispValid : display read, data one cycle later
//   nHostWr/nHostRd/hostAddr/hostWrData     : raw asynchronous host bus
//   hostRdData/hostRdValid                  : held host read result
//   wrFull/wrOverflow                       : FIFO full, sticky dropped-write flag
//   vramAddr/vramWrData/vramWe/vramRdData   : VRAM port (read latency 1)
// Optional feature macro: VRAM_ARB_HOST_READ_EN enables the host read path.
// Without it nHostRd is ignored and hostRdData/hostRdValid are tied low.
module vram_arbiter
   import vram_arb_pkg::*;
#(
   parameter int unsigned ADDR_W      = ADDR_W_DEFAULT,
   parameter int unsigned DATA_W      = DATA_W_DEFAULT,
   parameter int unsigned WFIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              dispReq,
   input  logic [ADDR_W-1:0] dispAddr,
   output logic [DATA_W-1:0] dispData,
   output logic              dispValid,
   input  logic              nHostWr,
   input  logic              nHostRd,
   input  logic [ADDR_W-1:0] hostAddr,
   input  logic [DATA_W-1:0] hostWrData,
   output logic [DATA_W-1:0] hostRdData,
   output logic              hostRdValid,
   output logic              wrFull,
   output logic              wrOverflow,
   output logic [ADDR_W-1:0] vramAddr,
   output logic [DATA_W-1:0] vramWrData,
   output logic              vramWe,
   input  logic [DATA_W-1:0] vramRdData
);

   localparam int unsigned ENTRY_W = ADDR_W + DATA_W;

   grant_t              grant;
   logic                fifoEmpty;
   logic [ENTRY_W-1:0]  fifoHead;
   logic [ADDR_W-1:0]   headAddr;
   logic [DATA_W-1:0]   headData;
   logic                dispValidQ;
   logic                overflowQ;

   // ---------------------------------------------------------------------------
   // Write strobe: 2-flop synchronizer, delayed copy, registered falling edge.
   // ---------------------------------------------------------------------------
   logic wrSync1Q, wrSync2Q, wrSync3Q, wrStrobeQ;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrSync1Q  <= 1'b1;
         wrSync2Q  <= 1'b1;
         wrSync3Q  <= 1'b1;
         wrStrobeQ <= 1'b0;
      end else begin
         wrSync1Q  <= nHostWr;
         wrSync2Q  <= wrSync1Q;
         wrSync3Q  <= wrSync2Q;
         wrStrobeQ <= wrSync3Q & ~wrSync2Q;
      end
   end

   vram_wr_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (WFIFO_DEPTH)
   ) uWrFifo (
      .clk      (clk),
      .rst      (rst),
      .push     (wrStrobeQ),
      .pushData ({hostAddr, hostWrData}),
      .pop      (grant == G_WR),
      .popData  (fifoHead),
      .full     (wrFull),
      .empty    (fifoEmpty)
   );

   assign {headAddr, headData} = fifoHead;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflowQ <= 1'b0;
      end else if (wrStrobeQ && wrFull) begin
         overflowQ <= 1'b1;
      end
   end

   assign wrOverflow = overflowQ;

`ifdef VRAM_ARB_HOST_READ_EN
   // ---------------------------------------------------------------------------
   // Host read path. A read is pending whenever the FSM is not IDLE.
   // ---------------------------------------------------------------------------
   logic              rdSync1Q, rdSync2Q, rdSync3Q, rdStrobeQ;
   logic [ADDR_W-1:0] rdAddrQ;
   logic [DATA_W-1:0] rdDataQ;
   logic              rdValidQ;
   logic              capture;
   arbState_t         stateQ, stateD;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdSync1Q  <= 1'b1;
         rdSync2Q  <= 1'b1;
         rdSync3Q  <= 1'b1;
         rdStrobeQ <= 1'b0;
      end else begin
         rdSync1Q  <= nHostRd;
         rdSync2Q  <= rdSync1Q;
         rdSync3Q  <= rdSync2Q;
         rdStrobeQ <= rdSync3Q & ~rdSync2Q;
      end
   end

   // A new strobe always wins: it re-latches the address and restarts the issue,
   // so only the most recent read is ever outstanding.
   always_comb begin
      stateD = stateQ;
      if (rdStrobeQ) begin
         stateD = RD_ISSUE;
      end else begin
         case (stateQ)
            IDLE:       stateD = IDLE;
            RD_ISSUE:   if (grant == G_RD) stateD = RD_CAPTURE;
            RD_CAPTURE: stateD = IDLE;
            default:    stateD = IDLE;
         endcase
      end
   end

   assign capture = (stateQ == RD_CAPTURE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stateQ   <= IDLE;
         rdAddrQ  <= '0;
         rdDataQ  <= '0;
         rdValidQ <= 1'b0;
      end else begin
         stateQ <= stateD;
         if (rdStrobeQ) rdAddrQ <= hostAddr;
         if (capture)   rdDataQ <= vramRdData;
         if (rdStrobeQ)     rdValidQ <= 1'b0;
         else if (capture)  rdValidQ <= 1'b1;
         else if (rdSync2Q) rdValidQ <= 1'b0;
      end
   end

   // During RD_CAPTURE the VRAM data is forwarded so the result is visible in the
   // capture cycle itself; the register then holds it.
   assign hostRdData  = capture ? vramRdData : rdDataQ;
   assign hostRdValid = (capture & ~rdStrobeQ) | rdValidQ;
`else
   logic unusedRd;
   assign unusedRd    = nHostRd;
   assign hostRdData  = '0;
   assign hostRdValid = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Slot grant: display, then posted writes, then the pending host read.
   // Reads sit behind every queued write, which keeps read-after-write coherent.
   // ---------------------------------------------------------------------------
   always_comb begin
      grant = G_NONE;
      if (dispReq) grant = G_DISP;
      else if (!fifoEmpty) grant = G_WR;
`ifdef VRAM_ARB_HOST_READ_EN
      else if (stateQ == RD_ISSUE) grant = G_RD;
`endif
   end

   always_comb begin
      vramAddr = dispAddr;
      vramWe   = 1'b0;
      if (grant == G_WR) begin
         vramAddr = headAddr;
         vramWe   = 1'b1;
      end
`ifdef VRAM_ARB_HOST_READ_EN
      else if (grant == G_RD) begin
         vramAddr = rdAddrQ;
      end
`endif
   end

   assign vramWrData = headData;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) dispValidQ <= 1'b0;
      else     dispValidQ <= dispReq;
   end

   assign dispValid = dispValidQ;
   assign dispData  = dispValidQ ? vramRdData : '0;

endmodule
